// File: rtl/memstream_rr_sched.sv
// Single-port weight-memory read scheduler: config access has absolute priority,
// stream consumers share the remaining cycles round-robin, and read data is tagged back to its requester.
module memstream_rr_sched #(
    parameter int           NSTREAMS     = 4,
    parameter int           MEM_DEPTH    = 13824,
    parameter int           MEM_WIDTH    = 32,
    parameter int           ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int           RD_LATENCY   = 2,
    parameter logic [191:0] STRM_OFFSETS = {32'd11520, 32'd9216, 32'd6912, 32'd4608, 32'd2304, 32'd0},
    parameter logic [191:0] STRM_DEPTHS  = {6{32'd2304}}
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  config_ce,
    input  logic                  config_we,
    input  logic [ADDR_WIDTH-1:0] config_address,
    input  logic [MEM_WIDTH-1:0]  config_d0,
    output logic [MEM_WIDTH-1:0]  config_q0,
    output logic                  config_rack,
    input  logic [NSTREAMS-1:0]   strm_afull,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_d,
    input  logic [MEM_WIDTH-1:0]  mem_q,
    output logic [NSTREAMS-1:0]   strm_valid,
    output logic [MEM_WIDTH-1:0]  strm_data
);

    logic [NSTREAMS-1:0][ADDR_WIDTH-1:0] w_ptrs;
    logic                                w_hi_vld;
    logic                                w_lo_vld;
    logic                                w_sgrant;
    logic [2:0]                          w_sid;
    logic [ADDR_WIDTH-1:0]               w_saddr;
    logic [2:0]                          r_last;
    logic [RD_LATENCY:0]                 r_tag_vld;
    logic [RD_LATENCY:0]                 r_tag_cfg;
    logic [RD_LATENCY:0][2:0]            r_tag_id;
    logic                                w_new_vld;
    logic [NSTREAMS-1:0]                 w_ret_sv;
    logic                                r_mem_ce;
    logic                                r_mem_we;
    logic [ADDR_WIDTH-1:0]               r_mem_addr;
    logic [MEM_WIDTH-1:0]                r_mem_d;
    logic [MEM_WIDTH-1:0]                r_config_q0;
    logic                                r_config_rack;
    logic [NSTREAMS-1:0]                 r_strm_valid;
    logic [MEM_WIDTH-1:0]                r_strm_data;

    // Round-robin search: first eligible stream above r_last, else wrap to the lowest eligible.
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_sid    = '0;
        w_saddr  = '0;
        for (int i = 0; i < NSTREAMS; i++) begin
            if (!w_hi_vld && !strm_afull[i] && (i > int'(r_last))) begin
                w_hi_vld = 1'b1;
                w_sid    = 3'(i);
                w_saddr  = w_ptrs[i];
            end
        end
        for (int i = 0; i < NSTREAMS; i++) begin
            if (!w_hi_vld && !w_lo_vld && !strm_afull[i]) begin
                w_lo_vld = 1'b1;
                w_sid    = 3'(i);
                w_saddr  = w_ptrs[i];
            end
        end
        w_sgrant = w_hi_vld | w_lo_vld;
    end

    for (genvar s = 0; s < NSTREAMS; s++) begin : g_ptr
        localparam logic [ADDR_WIDTH-1:0] OFF = ADDR_WIDTH'(STRM_OFFSETS[32*s +: 32]);
        localparam logic [ADDR_WIDTH-1:0] LST =
            ADDR_WIDTH'(STRM_OFFSETS[32*s +: 32] + STRM_DEPTHS[32*s +: 32] - 32'd1);
        logic [ADDR_WIDTH-1:0] r_ptr;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_ptr <= OFF;
            end else if (!config_ce && w_sgrant && (w_sid == 3'(s))) begin
                r_ptr <= (r_ptr == LST) ? OFF : r_ptr + ADDR_WIDTH'(1);
            end
        end

        assign w_ptrs[s] = r_ptr;
    end

    // Config writes occupy the memory port but return nothing, so they carry no valid tag.
    assign w_new_vld = config_ce ? !config_we : w_sgrant;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_d    <= '0;
            r_last     <= 3'(NSTREAMS - 1);
            r_tag_vld  <= '0;
            r_tag_cfg  <= '0;
            r_tag_id   <= '0;
        end else begin
            r_mem_ce  <= config_ce | w_sgrant;
            r_mem_we  <= config_ce & config_we;
            r_mem_d   <= config_ce ? config_d0 : '0;
            if (config_ce) begin
                r_mem_addr <= config_address;
            end else if (w_sgrant) begin
                r_mem_addr <= w_saddr;
                r_last     <= w_sid;
            end
            r_tag_vld <= {r_tag_vld[RD_LATENCY-1:0], w_new_vld};
            r_tag_cfg <= {r_tag_cfg[RD_LATENCY-1:0], config_ce};
            r_tag_id  <= {r_tag_id[RD_LATENCY-1:0], w_sid};
        end
    end

    always_comb begin
        w_ret_sv = '0;
        for (int i = 0; i < NSTREAMS; i++) begin
            w_ret_sv[i] = r_tag_vld[RD_LATENCY] && !r_tag_cfg[RD_LATENCY]
                          && (r_tag_id[RD_LATENCY] == 3'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_config_q0   <= '0;
            r_config_rack <= 1'b0;
            r_strm_valid  <= '0;
            r_strm_data   <= '0;
        end else begin
            r_config_rack <= r_tag_vld[RD_LATENCY] & r_tag_cfg[RD_LATENCY];
            r_strm_valid  <= w_ret_sv;
            if (r_tag_vld[RD_LATENCY] && r_tag_cfg[RD_LATENCY]) begin
                r_config_q0 <= mem_q;
            end
            if (r_tag_vld[RD_LATENCY] && !r_tag_cfg[RD_LATENCY]) begin
                r_strm_data <= mem_q;
            end
        end
    end

    assign mem_ce      = r_mem_ce;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_d       = r_mem_d;
    assign config_q0   = r_config_q0;
    assign config_rack = r_config_rack;
    assign strm_valid  = r_strm_valid;
    assign strm_data   = r_strm_data;

endmodule

// File: doc/memstream_rr_sched.md
# memstream_rr_sched

Read scheduler that shares one single-port weight memory between up to six stream consumers and the AXI-lite configuration port. Each cycle it grants at most one memory access: configuration has absolute priority, then streams in round-robin order. Each stream walks its own address window (OFFSET..OFFSET+DEPTH-1) cyclically. Returned words are tagged back to the issuing stream, and a full downstream FIFO holds its stream off through `afull`. The block sits between the AXI-lite IP-side port and the memory macro, in front of the per-stream output FIFOs.

## Interface
- NSTREAMS, 4, number of active streams, 1..6
- MEM_DEPTH, 13824, memory words
- MEM_WIDTH, 32, memory word width
- ADDR_WIDTH, $clog2(MEM_DEPTH), memory address width
- RD_LATENCY, 2, memory read latency in cycles from `mem_ce` to valid `mem_q`, 1..3
- STRM_OFFSETS, packed 6x32-bit {S5..S0}, default {11520,9216,6912,4608,2304,0}, base word address per stream
- STRM_DEPTHS, packed 6x32-bit, default all 2304, window length per stream (≥1)

Ports:
- aclk  in  1  clock; everything is rising-edge
- aresetn  in  1  asynchronous active-low reset
- config_ce  in  1  config access request, one-cycle pulse
- config_we  in  1  1 = write, 0 = read (qualified by config_ce)
- config_address  in  ADDR_WIDTH  config word address
- config_d0  in  MEM_WIDTH  config write data
- config_q0  out  MEM_WIDTH  config read data
- config_rack  out  1  one-cycle pulse, config_q0 valid
- strm_afull  in  NSTREAMS  per-stream downstream almost-full
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_d  out  MEM_WIDTH  memory write data
- mem_q  in  MEM_WIDTH  memory read data
- strm_valid  out  NSTREAMS  one-hot, data valid for stream i
- strm_data  out  MEM_WIDTH  shared stream data bus

## Operation
- Eligible streams: stream i is eligible when `strm_afull[i]` = 0.
- Arbitration at each edge:
  - `config_ce`=1 → config wins. Stream pointers and the RR pointer are unchanged.
  - Otherwise the first eligible stream wins, searching from `last+1` mod NSTREAMS upward. The winner's pointer advances and `last` = winner.
  - No eligible stream and no config request → idle, `mem_ce`=0.
- Stream pointer: reset value is OFFSET_i. It increments by 1 per grant. After OFFSET_i+DEPTH_i-1 it wraps to OFFSET_i.
- Issue register: a grant at edge k drives `mem_ce`/`mem_addr`/`mem_we`/`mem_d` during cycle k+1.
  - `mem_we`=1 only for config writes.
  - `mem_d` = `config_d0` captured at edge k.
- Tag pipeline: RD_LATENCY+1 stages, each holding {valid, is_config, id[2:0]}. Config writes do not insert a valid tag.
- Return: at tag exit, `mem_q` is registered into `strm_data` with `strm_valid[id]`=1, or into `config_q0` with `config_rack`=1.
- The RR pointer `last` resets to NSTREAMS-1, so stream 0 is granted first.
- NSTREAMS=1 degenerates to stream 0 plus config priority.
- Outputs for indices ≥ NSTREAMS are tied 0. `strm_afull` bits ≥ NSTREAMS are ignored.
- Ordering: no read/write coherency is enforced. Accesses complete in issue order.

## Timing
- Reset (aresetn=0, asynchronous) clears:
  - `mem_ce`, `mem_we`, `config_rack` and `strm_valid` to 0
  - `mem_addr`, `mem_d`, `config_q0` and `strm_data` to 0
  - all tags (in-flight reads are discarded)
  - pointers back to OFFSET_i
- Deassertion of aresetn takes effect at the next rising edge.
- Latency:
  - request or grant sampled at edge k → data on `strm_data`/`config_q0` in cycle k+2+RD_LATENCY
  - RD_LATENCY=2 gives 4 cycles.
- Throughput: one access per cycle. A single eligible stream is granted every cycle.
- Backpressure: `afull` must assert with ≥ RD_LATENCY+2 free FIFO slots. Data already issued is always delivered; it is never stalled or dropped.
- Simultaneous events:
  - config plus eligible streams → config is served, and the streams retry the next cycle.
  - `afull` rising in the same cycle as a would-be grant → no grant.
- `strm_valid` is one-hot or zero in every cycle. `config_rack` and any `strm_valid` are never high together.

## Test plan
- Reset, NSTREAMS=4, all afull=0, RD_LATENCY=2 → `mem_addr` sequence 0, 2304, 4608, 6912, 1, 2305, … from cycle 1. The first `strm_valid`=0001 appears in cycle 4 with data = mem[0].
- Wrap: STRM_DEPTHS all 3, single stream eligible → addresses 0, 1, 2, 0, 1, 2 on consecutive cycles, with `strm_valid[0]` continuous from cycle 4.
- Backpressure: assert `strm_afull`=0010 at cycle 10 → stream 1 receives no grants from edge 10. Tags already issued still deliver. After afull drops, stream 1 resumes at its next unread address, with none skipped or repeated.
- Config priority: `config_ce` read at address 5000 during full streaming → that cycle's `mem_addr`=5000, `config_rack` 4 cycles later with mem[5000]. The RR order continues from the same `last`.
- Config write then read of address 100 on consecutive cycles → `mem_we` pulse with `config_d0`=0xDEADBEEF, then `config_q0`=0xDEADBEEF.
- Reset mid-stream with 3 reads in flight → no `strm_valid` after reset. Post-reset addresses restart at the offsets, beginning with stream 0.
